uart_rx_oversample: RTL and testbench

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_os_tick.sv | 32 +++
 rtl/uart_rx_oversample.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared encodings and constants for the oversampling UART receiver
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } rx_state_t;

    localparam int OS_RATE   = 16;
    localparam int DATA_BITS = 8;

    localparam logic [3:0] SAMPLE_EARLY = 4'd7;
    localparam logic [3:0] SAMPLE_MID   = 4'd8;
    localparam logic [3:0] SAMPLE_LATE  = 4'd9;
    localparam logic [3:0] SAMPLE_LAST  = 4'(OS_RATE - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_os_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_os_tick
// Brief    : Free-running divider producing one oversample tick per OS_DIV clocks
// Revision : 1.0
// ============================================================================
module uart_os_tick #(
    parameter int OS_DIV = 651
) (
    input  logic clk_main,
    input  logic reset,
    output logic tick
);

    localparam logic [15:0] C_LAST = 16'(OS_DIV - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversample.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_oversample
// Brief    : 8N1 UART receiver, 16x oversampling, 3-sample majority vote
// Revision : 1.0
// ============================================================================
module uart_rx_oversample #(
    parameter int OS_DIV = 651
) (
    input  logic       clk_main,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy,
    output logic [1:0] rxstate
);
    import uart_pkg::*;

    logic       w_tick;
    logic [1:0] r_sync;
    logic       w_rx_s;
    rx_state_t  r_state;
    rx_state_t  w_state_next;
    logic [3:0] r_os_cnt;
    logic [2:0] r_bit_idx;
    logic       r_samp_early;
    logic       r_samp_mid;
    logic       r_stop_bad;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_frame_err;
    logic       r_overrun;
    logic       w_decide;
    logic       w_bit_end;
    logic       w_vote;
    logic       w_load;
    logic       w_ferr;
    logic       w_handshake;

    uart_os_tick #(
        .OS_DIV   (OS_DIV)
    ) u_tick (
        .clk_main (clk_main),
        .reset    (reset),
        .tick     (w_tick)
    );

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rx_s    = r_sync[1];
    assign w_decide  = w_tick && (r_os_cnt == SAMPLE_LATE);
    assign w_bit_end = w_tick && (r_os_cnt == SAMPLE_LAST);
    // The third vote is taken live at count 9, the first two were latched earlier
    assign w_vote    = majority3(r_samp_early, r_samp_mid, w_rx_s);

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && !w_rx_s) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_decide && w_vote)  w_state_next = ST_IDLE;
                else if (w_bit_end)      w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'(DATA_BITS - 1))) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                // After a bad stop bit, wait for the line to return high before rearming
                if (r_stop_bad) begin
                    if (w_tick && w_rx_s) w_state_next = ST_IDLE;
                end else if (w_decide) begin
                    if (w_vote) begin
                        w_load       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ferr = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            r_os_cnt     <= '0;
            r_bit_idx    <= '0;
            r_samp_early <= 1'b1;
            r_samp_mid   <= 1'b1;
            r_stop_bad   <= 1'b0;
            r_shift      <= '0;
        end else begin
            if (r_state == ST_IDLE)  r_os_cnt <= '0;
            else if (w_tick)         r_os_cnt <= r_os_cnt + 4'd1;

            if (w_tick && (r_os_cnt == SAMPLE_EARLY)) r_samp_early <= w_rx_s;
            if (w_tick && (r_os_cnt == SAMPLE_MID))   r_samp_mid   <= w_rx_s;

            if (r_state == ST_START)                  r_bit_idx <= '0;
            else if ((r_state == ST_DATA) && w_bit_end) r_bit_idx <= r_bit_idx + 3'd1;

            if ((r_state == ST_DATA) && w_decide) r_shift[r_bit_idx] <= w_vote;

            if (r_state == ST_IDLE) r_stop_bad <= 1'b0;
            else if (w_ferr)        r_stop_bad <= 1'b1;
        end
    end

    assign w_handshake = r_valid && rx_ready;

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            // A handshake in the load cycle frees the register for the new byte
            if (w_load) begin
                if (r_valid && !w_handshake) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign rx_busy   = (r_state != ST_IDLE);
    assign rxstate   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversample.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_oversample
// Brief    : Self-checking bench for uart_rx_oversample with OS_DIV=4
// Revision : 1.0
// ============================================================================
module tb_uart_rx_oversample;

    localparam int OS_DIV  = 4;
    localparam int BIT_CYC = 16 * OS_DIV;

    logic       clk_main = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;
    logic [1:0] rxstate;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fe_cnt  = 0;
    int ov_cnt  = 0;
    logic [7:0] exp_q[$];

    uart_rx_oversample #(.OS_DIV(OS_DIV)) dut (
        .clk_main  (clk_main),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy),
        .rxstate   (rxstate)
    );

    always #5 clk_main = ~clk_main;

    // Clock count since reset release; the DUT tick is consumed at edges with cyc%4==0
    always @(posedge clk_main or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk_main) begin
        if (frame_err) fe_cnt = fe_cnt + 1;
        if (overrun)   ov_cnt = ov_cnt + 1;
    end

    // Frame starts on the negedge after an edge with cyc%4==1, which puts the
    // synchronized samples 7/8/9 of each bit at bit-relative edges 33/37/41
    task automatic send_frame(input logic [7:0] data, input int stop_len, input logic stop_val,
                              input bit glitch, input bit pulse_ready, output logic [1:0] st_end);
        logic v;
        rx = 1'b1;
        repeat (20) @(negedge clk_main);
        do @(negedge clk_main); while ((cyc % OS_DIV) != 1);
        for (int p = 0; p < 9 + stop_len; p++) begin
            v = (p == 0) ? 1'b0 : (p <= 8) ? data[p-1] : stop_val;
            for (int j = 0; j < BIT_CYC; j++) begin
                if (j == 0) rx = v;
                if (glitch && p == 4 && j == 35) rx = 1'b0;
                if (glitch && p == 4 && j == 39) rx = v;
                if (pulse_ready && p == 9 && j == 42) rx_ready = 1'b1;
                if (pulse_ready && p == 9 && j == 43) rx_ready = 1'b0;
                @(negedge clk_main);
            end
        end
        st_end = rxstate;
        rx = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_main);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_main);
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        n_tests++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got fe=%b ov=%b expected 0 0", frame_err, overrun); end
        n_tests++; if (rx_busy !== 1'b0 || rxstate !== 2'b00) begin n_fail++; $display("FAIL reset_state: got busy=%b state=%b expected 0 00", rx_busy, rxstate); end
        reset = 1'b0;
        repeat (40) @(negedge clk_main);
        n_tests++; if (rxstate !== 2'b00 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got state=%b valid=%b expected 00 0", rxstate, rx_valid); end
    endtask

    task automatic test_basic();
        logic [1:0] st;
        logic [7:0] exp;
        bit ok;
        int fe0, ov0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        rx_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1, 1'b1, 1'b0, 1'b0, st);
        wait_valid(200, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_valid_timeout: got valid=%b expected 1", rx_valid); end
        exp = exp_q.pop_front();
        n_tests++; if (rx_data !== exp) begin n_fail++; $display("FAIL basic_data: got %h expected %h", rx_data, exp); end
        n_tests++; if (st !== 2'b00) begin n_fail++; $display("FAIL basic_early_idle: got state=%b expected 00", st); end
        n_tests++; if (fe_cnt != fe0 || ov_cnt != ov0) begin n_fail++; $display("FAIL basic_pulses: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0); end
        repeat (5) @(negedge clk_main);
        n_tests++; if (rx_valid !== 1'b1 || rx_data !== exp) begin n_fail++; $display("FAIL basic_hold: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, exp); end
        rx_ready = 1'b1;
        @(negedge clk_main);
        rx_ready = 1'b0;
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_handshake_clear: got valid=%b expected 0", rx_valid); end
    endtask

    task automatic test_false_start();
        bit saw_start, saw_beyond;
        int fe0;
        fe0 = fe_cnt;
        saw_start = 1'b0; saw_beyond = 1'b0;
        rx = 1'b1;
        repeat (20) @(negedge clk_main);
        do @(negedge clk_main); while ((cyc % OS_DIV) != 1);
        rx = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i == 4 * OS_DIV) rx = 1'b1;
            if (rxstate === 2'b01) saw_start = 1'b1;
            if (rxstate === 2'b10 || rxstate === 2'b11) saw_beyond = 1'b1;
            @(negedge clk_main);
        end
        n_tests++; if (!saw_start || saw_beyond) begin n_fail++; $display("FAIL false_start_path: got start=%b beyond=%b expected 1 0", saw_start, saw_beyond); end
        n_tests++; if (rxstate !== 2'b00) begin n_fail++; $display("FAIL false_start_idle: got state=%b expected 00", rxstate); end
        n_tests++; if (rx_valid !== 1'b0 || fe_cnt != fe0) begin n_fail++; $display("FAIL false_start_outputs: got valid=%b fe=%0d expected 0 0", rx_valid, fe_cnt - fe0); end
    endtask

    task automatic test_frame_err();
        logic [1:0] st;
        logic [7:0] exp;
        bit ok;
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h3C, 2, 1'b0, 1'b0, 1'b0, st);
        n_tests++; if (st !== 2'b11) begin n_fail++; $display("FAIL ferr_hold_stop: got state=%b expected 11", st); end
        n_tests++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL ferr_pulse_count: got %0d expected 1", fe_cnt - fe0); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_no_valid: got %b expected 0", rx_valid); end
        repeat (12) @(negedge clk_main);
        n_tests++; if (rxstate !== 2'b00) begin n_fail++; $display("FAIL ferr_recover_idle: got state=%b expected 00", rxstate); end
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1, 1'b1, 1'b0, 1'b0, st);
        wait_valid(200, ok);
        exp = exp_q.pop_front();
        n_tests++; if (!ok || rx_data !== exp) begin n_fail++; $display("FAIL ferr_next_byte: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, exp); end
        n_tests++; if (fe_cnt - fe0 != 1) begin n_fail++; $display("FAIL ferr_no_extra_pulse: got %0d expected 1", fe_cnt - fe0); end
        rx_ready = 1'b1;
        @(negedge clk_main);
        rx_ready = 1'b0;
    endtask

    task automatic test_overrun();
        logic [1:0] st;
        logic [7:0] exp;
        int ov0;
        ov0 = ov_cnt;
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1, 1'b1, 1'b0, 1'b0, st);
        send_frame(8'h22, 1, 1'b1, 1'b0, 1'b0, st);
        exp = exp_q.pop_front();
        n_tests++; if (ov_cnt - ov0 != 1) begin n_fail++; $display("FAIL overrun_count: got %0d expected 1", ov_cnt - ov0); end
        n_tests++; if (rx_valid !== 1'b1 || rx_data !== exp) begin n_fail++; $display("FAIL overrun_keep: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, exp); end
        rx_ready = 1'b1;
        @(negedge clk_main);
        rx_ready = 1'b0;

        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1, 1'b1, 1'b0, 1'b0, st);
        exp = exp_q.pop_front();
        n_tests++; if (rx_valid !== 1'b1 || rx_data !== exp) begin n_fail++; $display("FAIL same_cycle_first: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, exp); end
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1, 1'b1, 1'b0, 1'b1, st);
        exp = exp_q.pop_front();
        n_tests++; if (rx_valid !== 1'b1 || rx_data !== exp) begin n_fail++; $display("FAIL same_cycle_load: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, exp); end
        n_tests++; if (ov_cnt != ov0) begin n_fail++; $display("FAIL same_cycle_no_overrun: got %0d expected 0", ov_cnt - ov0); end
        rx_ready = 1'b1;
        @(negedge clk_main);
        rx_ready = 1'b0;
    endtask

    task automatic test_glitch();
        logic [1:0] st;
        logic [7:0] exp;
        bit ok;
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1, 1'b1, 1'b1, 1'b0, st);
        wait_valid(200, ok);
        exp = exp_q.pop_front();
        n_tests++; if (!ok || rx_data !== exp) begin n_fail++; $display("FAIL glitch_vote: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, exp); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] st;
        logic [7:0] exp;
        logic [7:0] partial;
        bit ok;
        partial = 8'h0F;
        rx = 1'b1;
        repeat (20) @(negedge clk_main);
        do @(negedge clk_main); while ((cyc % OS_DIV) != 1);
        for (int p = 0; p < 5; p++) begin
            rx = (p == 0) ? 1'b0 : partial[p-1];
            repeat ((p == 4) ? 20 : BIT_CYC) @(negedge clk_main);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk_main);
        n_tests++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_holding: got valid=%b data=%h expected 0 00", rx_valid, rx_data); end
        n_tests++; if (rxstate !== 2'b00 || rx_busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got state=%b busy=%b fe=%b ov=%b expected 00 0 0 0", rxstate, rx_busy, frame_err, overrun); end
        rx = 1'b1;
        reset = 1'b0;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1, 1'b1, 1'b0, 1'b0, st);
        wait_valid(200, ok);
        exp = exp_q.pop_front();
        n_tests++; if (!ok || rx_data !== exp) begin n_fail++; $display("FAIL midreset_next_byte: got valid=%b data=%h expected 1 %h", rx_valid, rx_data, exp); end
    endtask

    initial begin
        reset    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (2) @(negedge clk_main);
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
